data_memory: RTL and testbench
==============================

# data_memory

Byte-addressed data memory for the single-cycle RV32I core. It serves loads and stores of byte, halfword and word width at any byte address, with no alignment restriction. Endianness is selected by a parameter, and addresses wrap modulo the memory size. Reads are combinational; writes commit on the rising clock edge.

## Interface
- `ENDIANNESS`, default 1; 0 = big-endian, 1 = little-endian.
- `SIZE`, default 10; number of bytes of storage.
- `clock`  in  1  system clock; writes on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all memory.
- `address`  in  32  byte address of the access, for both read and write.
- `flagsForReading`  in  3  load type:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `flagsForWriting`  in  2  store type: 00 SB, 01 SH, 10 SW.
- `valueForWriting`  in  32  store data; the low 8/16/32 bits are used.
- `writeEnable`  in  1  store strobe, active-high.
- `value`  out  32  load result, combinational.
- Storage `memory[0:SIZE-1]`, 8 bits each, named exactly so for hierarchical inspection by benches.

## Operation
- **Lane index.** Byte lane k (k = 0..3) maps to memory index (address mod SIZE + k) mod SIZE. Wrap-around past the last byte returns to index 0.
- **Little-endian.** Lane k holds data bits [8k+7:8k]. Lane 0 is least significant.
- **Big-endian.** Lane 0 holds the most significant byte of the access width:
  - word: lanes 0..3 = bits 31:24, 23:16, 15:8, 7:0.
  - half: lanes 0..1 = bits 15:8, 7:0.
  - byte: lane 0 = bits 7:0.
- **Store.** When `writeEnable`=1 at a rising `clock`, write 1, 2 or 4 lanes per `flagsForWriting`. All other bytes are unchanged.
  - `flagsForWriting`=11 writes nothing.
  - `writeEnable`=0 writes nothing, regardless of the other inputs.
- **Load.** `value` is assembled from the addressed lanes per endianness:
  - LB / LH: sign-extend from bit 7 / bit 15.
  - LBU / LHU: zero-extend.
  - LW: 32 bits unchanged.
  - `flagsForReading`=011 behaves as LW.
  - `flagsForReading`=11x yields 0.
- **Reset.** `reset`=0 clears every byte to 0 immediately, independent of `clock`. Reset overrides any simultaneous write.

## Timing
- `value` is purely combinational from `address`, `flagsForReading` and `memory`. It settles in the same cycle with zero latency.
- A store is visible on `value` immediately after the rising edge that commits it.
- While `reset` is low, `value` reads 0 for all load types.
- Power-up contents are 0. After reset deasserts, the memory is writable on the next rising edge.
- There is no handshake and no stall; one access per cycle.
- Read-during-write at the same edge: `value` shows old data before the edge and new data after.

## Structure
- Shared package `datamem_pkg` holds:
  - the load-code enum: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101;
  - the store-code enum: SB=2'b00, SH=2'b01, SW=2'b10;
  - endianness constants: BIG=0, LITTLE=1.
- The decoder and core import this package.
- No sub-module is needed. Lane-index wrap logic is a local function: compute base = address % SIZE, add k, then subtract SIZE if the result is ≥ SIZE.

## Test plan
- **Reset and idle.** After reset, every `memory[i]` is 0 and `value`=0 for addresses 0..9 in both endiannesses.
- **Write gating.** With `writeEnable`=0, clock `valueForWriting`=i+10 at addresses 0..9. Memory must stay all 0.
- **Byte fill and async clear.** SB of 0x11 at addresses 0..9 gives every byte = 0x11. Pulsing `reset` low mid-cycle, with no clock edge, clears all bytes to 0.
- **Mixed stores.** Store in order: SW 0xAABBCCDD at address 1, SH 0x66778899 at address 9 (wraps to index 0), SB 0x112233EE at address 5.
  - Then LW at address 9 returns BE 0x8899AABB, LE 0xCCDD8899.
- **Half loads** on the same memory image:
  - LH at address 4: BE 0xFFFFDDEE, LE 0xFFFFEEAA.
  - LHU at address 3: BE 0x0000CCDD, LE 0x0000AABB.
- **Byte loads** on the same image:
  - LB at address 0: BE 0xFFFFFF99, LE 0xFFFFFF88.
  - LBU at address 0: BE 0x00000099, LE 0x00000088.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared definitions for the RV32I data memory: load/store codes and
// endianness selectors, plus a small store-width helper.
package datamem_pkg;

  // Load type codes as they arrive from the instruction decoder.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } loadType_e;

  // Store type codes; 2'b11 is unused and writes nothing.
  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10
  } storeType_e;

  // Endianness selectors for the ENDIANNESS parameter.
  localparam int BIG    = 0;
  localparam int LITTLE = 1;

  // Lane-enable mask for a store code (lane 0 is the addressed byte).
  function automatic logic [3:0] storeLaneMask(input logic [1:0] flags);
    logic [3:0] mask;
    case (flags)
      SB:      mask = 4'b0001;
      SH:      mask = 4'b0011;
      SW:      mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed data memory with unaligned byte/half/word access,
// modulo-SIZE address wrap, selectable endianness, combinational reads
// and rising-edge writes. Asynchronous active-low reset clears storage.
module data_memory
  import datamem_pkg::*;
#(
  parameter int ENDIANNESS = 1,
  parameter int SIZE       = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [2:0]  flagsForReading,
  input  logic [1:0]  flagsForWriting,
  input  logic [31:0] valueForWriting,
  input  logic        writeEnable,
  output logic [31:0] value
);

  localparam int          IDXW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] SIZE_U = 32'(SIZE);

  logic [7:0]      memory [0:SIZE-1];

  logic [IDXW-1:0] laneIdx_s  [0:3];
  logic [7:0]      laneByte_s [0:3];
  logic [7:0]      laneData_s [0:3];
  logic [3:0]      laneEn_s;
  logic [31:0]     wordRaw_s;
  logic [15:0]     halfRaw_s;
  logic [7:0]      byteRaw_s;

  // Memory index of a byte lane: base = address mod SIZE, plus lane,
  // folded back once because base + lane stays below 2*SIZE for SIZE >= 4.
  function automatic logic [IDXW-1:0] laneIndex(input logic [31:0] addr,
                                                input logic [1:0]  lane);
    logic [31:0] idx;
    idx = (addr % SIZE_U) + {30'd0, lane};
    if (idx >= SIZE_U) begin
      idx = idx - SIZE_U;
    end else begin
      idx = idx;
    end
    return idx[IDXW-1:0];
  endfunction

  // Resolve the four lane indices and the bytes currently stored there.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      laneIdx_s[k]  = laneIndex(address, 2'(k));
      laneByte_s[k] = memory[laneIdx_s[k]];
    end
  end

  // Map store data onto lanes according to width and endianness.
  always_comb begin
    laneEn_s = storeLaneMask(flagsForWriting);
    for (int k = 0; k < 4; k++) begin
      laneData_s[k] = 8'h00;
    end
    if (ENDIANNESS == LITTLE) begin
      for (int k = 0; k < 4; k++) begin
        laneData_s[k] = valueForWriting[8*k +: 8];
      end
    end else begin
      case (flagsForWriting)
        SB: begin
          laneData_s[0] = valueForWriting[7:0];
        end
        SH: begin
          laneData_s[0] = valueForWriting[15:8];
          laneData_s[1] = valueForWriting[7:0];
        end
        SW: begin
          laneData_s[0] = valueForWriting[31:24];
          laneData_s[1] = valueForWriting[23:16];
          laneData_s[2] = valueForWriting[15:8];
          laneData_s[3] = valueForWriting[7:0];
        end
        default: begin
          laneData_s[0] = 8'h00;
        end
      endcase
    end
  end

  // Storage: asynchronous clear wins over any write; enabled lanes commit on the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        memory[i] <= 8'h00;
      end
    end else if (writeEnable) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn_s[k]) begin
          memory[laneIdx_s[k]] <= laneData_s[k];
        end
      end
    end
  end

  // Assemble raw byte/half/word from the lanes; lane 0 is MSB in big-endian.
  always_comb begin
    if (ENDIANNESS == LITTLE) begin
      wordRaw_s = {laneByte_s[3], laneByte_s[2], laneByte_s[1], laneByte_s[0]};
      halfRaw_s = {laneByte_s[1], laneByte_s[0]};
    end else begin
      wordRaw_s = {laneByte_s[0], laneByte_s[1], laneByte_s[2], laneByte_s[3]};
      halfRaw_s = {laneByte_s[0], laneByte_s[1]};
    end
    byteRaw_s = laneByte_s[0];
  end

  // Apply the load type: sign/zero extension, word pass-through, 11x reads zero.
  always_comb begin
    value = 32'h0000_0000;
    case (flagsForReading)
      LB:      value = {{24{byteRaw_s[7]}}, byteRaw_s};
      LH:      value = {{16{halfRaw_s[15]}}, halfRaw_s};
      LW:      value = wordRaw_s;
      3'b011:  value = wordRaw_s;
      LBU:     value = {24'h00_0000, byteRaw_s};
      LHU:     value = {16'h0000, halfRaw_s};
      default: value = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: one big-endian and one little-endian
// instance share all inputs and are checked against a byte-array model.
module tb_data_memory;

  localparam int MSIZE = 10;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [2:0]  flagsForReading;
  logic [1:0]  flagsForWriting;
  logic [31:0] valueForWriting;
  logic        writeEnable;
  logic [31:0] valueBe;
  logic [31:0] valueLe;

  // Reference image: index 0 = big-endian instance, 1 = little-endian instance.
  logic [7:0] mdl [0:1][0:MSIZE-1];

  int nChecks = 0;
  int nFail   = 0;

  data_memory #(.ENDIANNESS(0), .SIZE(MSIZE)) dutBe (
    .clock(clock), .reset(reset), .address(address),
    .flagsForReading(flagsForReading), .flagsForWriting(flagsForWriting),
    .valueForWriting(valueForWriting), .writeEnable(writeEnable),
    .value(valueBe)
  );

  data_memory #(.ENDIANNESS(1), .SIZE(MSIZE)) dutLe (
    .clock(clock), .reset(reset), .address(address),
    .flagsForReading(flagsForReading), .flagsForWriting(flagsForWriting),
    .valueForWriting(valueForWriting), .writeEnable(writeEnable),
    .value(valueLe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void mdlClear();
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < MSIZE; i++)
        mdl[e][i] = 8'h00;
  endfunction

  // Store: n bytes at consecutive wrapped indices; little-endian puts the
  // least significant byte first, big-endian the most significant first.
  function automatic void mdlStore(input logic [31:0] addr, input logic [1:0] f,
                                   input logic [31:0] data);
    int n;
    int idx;
    n = (f == 2'd0) ? 1 : (f == 2'd1) ? 2 : (f == 2'd2) ? 4 : 0;
    for (int k = 0; k < n; k++) begin
      idx = int'((addr % 32'd10 + 32'(k)) % 32'd10);
      mdl[1][idx] = 8'((data >> (8 * k)) & 32'hFF);
      mdl[0][idx] = 8'((data >> (8 * (n - 1 - k))) & 32'hFF);
    end
  endfunction

  function automatic logic [31:0] mdlLoad(input int e, input logic [31:0] addr,
                                          input logic [2:0] f);
    int n;
    int idx;
    logic [31:0] raw;
    if (f == 3'b110 || f == 3'b111) return 32'h0;
    n = (f == 3'b000 || f == 3'b100) ? 1 : (f == 3'b001 || f == 3'b101) ? 2 : 4;
    raw = 32'h0;
    for (int k = 0; k < n; k++) begin
      idx = int'((addr % 32'd10 + 32'(k)) % 32'd10);
      if (e == 1) raw = raw + ({24'h0, mdl[e][idx]} << (8 * k));
      else        raw = (raw << 8) + {24'h0, mdl[e][idx]};
    end
    if (f == 3'b000 && raw >= 32'h80)   raw = raw + 32'hFFFF_FF00;
    if (f == 3'b001 && raw >= 32'h8000) raw = raw + 32'hFFFF_0000;
    return raw;
  endfunction

  task automatic checkMem(input string tag);
    for (int i = 0; i < MSIZE; i++) begin
      chk($sformatf("%s_be_mem%0d", tag, i), {24'h0, dutBe.memory[i]}, {24'h0, mdl[0][i]});
      chk($sformatf("%s_le_mem%0d", tag, i), {24'h0, dutLe.memory[i]}, {24'h0, mdl[1][i]});
    end
  endtask

  task automatic checkLoads(input string tag);
    chk({tag, "_be"}, valueBe, mdlLoad(0, address, flagsForReading));
    chk({tag, "_le"}, valueLe, mdlLoad(1, address, flagsForReading));
  endtask

  // One clock edge; the model commits what the DUT should have committed.
  task automatic step();
    @(posedge clock);
    if (writeEnable && reset) mdlStore(address, flagsForWriting, valueForWriting);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] expBe, input logic [31:0] expLe);
    address = a;
    flagsForReading = f;
    #1;
    chk({tag, "_be"}, valueBe, expBe);
    chk({tag, "_le"}, valueLe, expLe);
    checkLoads({tag, "_mdl"});
  endtask

  initial begin
    reset = 1'b0;
    address = 32'h0;
    flagsForReading = 3'b010;
    flagsForWriting = 2'b00;
    valueForWriting = 32'h0;
    writeEnable = 1'b0;
    mdlClear();

    // Reset held: storage and loads are zero.
    #12;
    checkMem("rst");
    for (int i = 0; i < MSIZE; i++) begin
      address = 32'(i);
      flagsForReading = 3'($urandom_range(0, 7));
      #1;
      chk("rst_val_be", valueBe, 32'h0);
      chk("rst_val_le", valueLe, 32'h0);
    end

    // Idle after release.
    @(negedge clock);
    reset = 1'b1;
    flagsForReading = 3'b010;
    for (int i = 0; i < MSIZE; i++) begin
      address = 32'(i);
      #1;
      chk("idle_be", valueBe, 32'h0);
      chk("idle_le", valueLe, 32'h0);
    end

    // Write gating: strobe low writes nothing.
    for (int i = 0; i < MSIZE; i++) begin
      @(negedge clock);
      address = 32'(i);
      valueForWriting = 32'(i + 10);
      flagsForWriting = 2'($urandom_range(0, 3));
      writeEnable = 1'b0;
      step();
    end
    checkMem("gate");

    // Byte fill, then an asynchronous clear between edges.
    for (int i = 0; i < MSIZE; i++) begin
      @(negedge clock);
      address = 32'(i);
      flagsForWriting = 2'b00;
      valueForWriting = 32'h11;
      writeEnable = 1'b1;
      step();
    end
    checkMem("fill");
    chk("fill_byte", {24'h0, dutLe.memory[7]}, 32'h11);
    @(negedge clock);
    writeEnable = 1'b0;
    #2;
    reset = 1'b0;
    mdlClear();
    #1;
    checkMem("aclr");
    flagsForReading = 3'b010;
    #0;
    chk("aclr_val_be", valueBe, 32'h0);
    chk("aclr_val_le", valueLe, 32'h0);
    #1;
    reset = 1'b1;

    // Mixed stores including wrap past the last byte.
    @(negedge clock);
    address = 32'd1; flagsForWriting = 2'b10; valueForWriting = 32'hAABBCCDD; writeEnable = 1'b1;
    step();
    @(negedge clock);
    address = 32'd9; flagsForWriting = 2'b01; valueForWriting = 32'h66778899;
    step();
    @(negedge clock);
    address = 32'd5; flagsForWriting = 2'b00; valueForWriting = 32'h112233EE;
    step();
    @(negedge clock);
    writeEnable = 1'b0;
    checkMem("mixed");
    directed("lw9",  32'd9, 3'b010, 32'h8899AABB, 32'hCCDD8899);
    directed("lh4",  32'd4, 3'b001, 32'hFFFFDDEE, 32'hFFFFEEAA);
    directed("lhu3", 32'd3, 3'b101, 32'h0000CCDD, 32'h0000AABB);
    directed("lb0",  32'd0, 3'b000, 32'hFFFFFF99, 32'hFFFFFF88);
    directed("lbu0", 32'd0, 3'b100, 32'h00000099, 32'h00000088);
    directed("lw011", 32'd9, 3'b011, 32'h8899AABB, 32'hCCDD8899);
    directed("ld11x", 32'd1, 3'b110, 32'h0, 32'h0);

    // Randomized traffic; read-during-write shows old data then new data.
    for (int it = 0; it < 300; it++) begin
      @(negedge clock);
      address = (it % 3 == 0) ? $urandom : 32'($urandom_range(0, 12));
      flagsForWriting = 2'($urandom_range(0, 3));
      valueForWriting = $urandom;
      writeEnable = 1'($urandom_range(0, 1));
      flagsForReading = 3'($urandom_range(0, 7));
      #1;
      checkLoads("rnd_pre");
      step();
      checkLoads("rnd_post");
      if (it % 50 == 49) checkMem("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
